// File: rtl/arm_pipeline_core.sv
// arm_pipeline_core: control-path skeleton of a 5-stage ARM pipeline.
// IF fetches big-endian words from a byte ROM, ID decodes a 12-bit
// control word, and EX/MEM/WB carry it forward, narrowing per stage.
// Ports: Clk   - rising-edge clock
//        Reset - asynchronous active-high reset
// S is a hold-only bubble select with no functional driver.

module arm_imem #(
   parameter int BYTES = 256,
   parameter int AW    = $clog2(BYTES)
) (
   input  logic [AW-1:0] addr_i,
   output logic [31:0]   rdata_o
);
   // Loaded from outside; there is no write port.
   reg [7:0] Mem [0:BYTES-1];

   logic [AW-1:0] a1, a2, a3;

   // Byte addresses wrap within the ROM.
   assign a1 = addr_i + AW'(1);
   assign a2 = addr_i + AW'(2);
   assign a3 = addr_i + AW'(3);

   assign rdata_o = {Mem[addr_i], Mem[a1], Mem[a2], Mem[a3]};
endmodule

module arm_control_unit (
   input  logic [31:0] instruction_i,
   output logic [11:0] control_signals
);
   logic is_dp, is_ls, is_br;
   logic [3:0] op;
   logic unused_instr;

   assign is_dp = instruction_i[27:26] == 2'b00;
   assign is_ls = instruction_i[27:26] == 2'b01;
   assign is_br = instruction_i[27:25] == 3'b101;
   assign op    = instruction_i[24:21];

   // Condition field and operand fields play no part in decode.
   assign unused_instr = ^{instruction_i[31:28], instruction_i[19:0]};

   always_comb begin
      control_signals = '0;
      // An all-zero word is a NOP, not an AND with rf_en set.
      if (instruction_i != '0) begin
         unique case (1'b1)
            is_dp: begin
               control_signals[11:8] = op;
               control_signals[7]    = instruction_i[25];
               // TST/TEQ/CMP/CMN only set flags.
               control_signals[5]    = op[3:2] != 2'b10;
            end
            is_ls: begin
               control_signals[11:8] = instruction_i[23] ? 4'b0100
                                                         : 4'b0010;
               control_signals[7]    = ~instruction_i[25];
               control_signals[6]    = instruction_i[20];
               control_signals[5]    = instruction_i[20];
               control_signals[4]    = instruction_i[22];
               control_signals[3]    = ~instruction_i[20];
               control_signals[2]    = 1'b1;
            end
            is_br: begin
               control_signals[5] = instruction_i[24];
               control_signals[1] = 1'b1;
               control_signals[0] = instruction_i[24];
            end
            default: ;
         endcase
      end
   end
endmodule

module arm_pipeline_core #(
   parameter int IMEM_BYTES = 256
) (
   input logic Clk,
   input logic Reset
);
   localparam int AW = $clog2(IMEM_BYTES);

   logic [31:0] PC, PC_d;
   logic [31:0] IF_ID_instruction;
   logic        S;
   logic [31:0] fetch_word;
   logic [11:0] control_signals;
   logic [11:0] ex_ctrl_d;
   logic [4:0]  mem_ctrl_d;
   logic [1:0]  wb_ctrl_d;
   logic [11:0] EX_control_signals;
   logic [4:0]  MEM_control_signals;
   logic [1:0]  WB_control_signals;
   logic        unused_ctrl;

   arm_imem #(
      .BYTES (IMEM_BYTES)
   ) imem (
      .addr_i  (PC[AW-1:0]),
      .rdata_o (fetch_word)
   );

   arm_control_unit control_unit (
      .instruction_i   (IF_ID_instruction),
      .control_signals (control_signals)
   );

   always_comb begin
      PC_d      = PC + 32'd4;
      ex_ctrl_d = S ? 12'b0 : control_signals;
      // MEM keeps {mem_size, mem_rw, mem_en, load, rf_en}.
      mem_ctrl_d = {EX_control_signals[4],
                    EX_control_signals[3],
                    EX_control_signals[2],
                    EX_control_signals[6],
                    EX_control_signals[5]};
      // WB keeps {load, rf_en}.
      wb_ctrl_d = MEM_control_signals[1:0];
   end

   // Fields not consumed in this skeleton.
   assign unused_ctrl = ^{EX_control_signals[11:7],
                          EX_control_signals[1:0],
                          MEM_control_signals[4:2],
                          WB_control_signals};

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         PC                  <= '0;
         IF_ID_instruction   <= '0;
         S                   <= 1'b0;
         EX_control_signals  <= '0;
         MEM_control_signals <= '0;
         WB_control_signals  <= '0;
      end else begin
         PC                  <= PC_d;
         IF_ID_instruction   <= fetch_word;
         S                   <= S;
         EX_control_signals  <= ex_ctrl_d;
         MEM_control_signals <= mem_ctrl_d;
         WB_control_signals  <= wb_ctrl_d;
      end
   end
endmodule

// File: tb/tb_arm_pipeline_core.sv
// tb_arm_pipeline_core: scoreboard bench for arm_pipeline_core.
// Streams a ROM program, forces S for a window, then resets mid-run.

module tb_arm_pipeline_core;
   logic Clk = 1'b0;
   logic Reset = 1'b1;

   always #5 Clk = ~Clk;

   arm_pipeline_core #(
      .IMEM_BYTES (256)
   ) dut (
      .Clk   (Clk),
      .Reset (Reset)
   );

   localparam int NCYC  = 140;
   localparam int S_ON  = 30;
   localparam int S_OFF = 90;

   int checks = 0;
   int errors = 0;

   logic [7:0]  mem_m [256];
   logic [11:0] ex_q  [$];
   logic [4:0]  mem_q [$];
   logic [1:0]  wb_q  [$];

   logic [31:0] prog   [6];
   logic [11:0] cs_tbl [6];
   logic [4:0]  mem_tbl[6];
   logic [1:0]  wb_tbl [6];

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] word_at(logic [31:0] a);
      logic [7:0] b;
      b = a[7:0];
      return {mem_m[b], mem_m[b + 8'd1], mem_m[b + 8'd2], mem_m[b + 8'd3]};
   endfunction

   function automatic logic [11:0] dec(logic [31:0] w);
      logic [11:0] r;
      logic [3:0]  op;
      r = '0;
      op = w[24:21];
      if (w == 32'b0) return r;
      if (w[27:26] == 2'b00) begin
         r[11:8] = op;
         r[7]    = w[25];
         r[5]    = !(op >= 4'd8 && op <= 4'd11);
      end else if (w[27:26] == 2'b01) begin
         r[11:8] = w[23] ? 4'b0100 : 4'b0010;
         r[7]    = !w[25];
         r[6]    = w[20];
         r[5]    = w[20];
         r[4]    = w[22];
         r[3]    = !w[20];
         r[2]    = 1'b1;
      end else if (w[27:25] == 3'b101) begin
         r[1] = 1'b1;
         r[0] = w[24];
         r[5] = w[24];
      end
      return r;
   endfunction

   function automatic logic [4:0] narrow(logic [11:0] c);
      return {c[4], c[3], c[2], c[6], c[5]};
   endfunction

   function automatic bit s_at(int e);
      return e >= S_ON && e <= S_OFF;
   endfunction

   initial begin
      logic [31:0] w;
      logic [11:0] cs;
      logic [31:0] exp_ex;

      prog    = '{32'hE3A01005, 32'hE5912004, 32'hE5C13000,
                  32'hE1530001, 32'hEB000002, 32'h00000000};
      cs_tbl  = '{12'b110110100000, 12'b010011100100,
                  12'b010010011100, 12'b101000000000,
                  12'b000000100011, 12'b000000000000};
      mem_tbl = '{5'b00001, 5'b00111, 5'b11100,
                  5'b00000, 5'b00001, 5'b00000};
      wb_tbl  = '{2'b01, 2'b11, 2'b00, 2'b00, 2'b01, 2'b00};

      for (int i = 0; i < 64; i++) begin
         w = (i < 6) ? prog[i] : $urandom();
         mem_m[4*i]   = w[31:24];
         mem_m[4*i+1] = w[23:16];
         mem_m[4*i+2] = w[15:8];
         mem_m[4*i+3] = w[7:0];
      end
      for (int i = 0; i < 256; i++) dut.imem.Mem[i] = mem_m[i];

      repeat (3) @(posedge Clk);
      #1;
      check("rst_pc", dut.PC, 32'd0);
      check("rst_ir", dut.IF_ID_instruction, 32'd0);
      check("rst_s", 32'(dut.S), 32'd0);
      check("rst_ex", 32'(dut.EX_control_signals), 32'd0);
      check("rst_mem", 32'(dut.MEM_control_signals), 32'd0);
      check("rst_wb", 32'(dut.WB_control_signals), 32'd0);

      // Stages hold zeros from reset until real work reaches them.
      ex_q.push_back('0);
      mem_q.push_back('0);
      mem_q.push_back('0);
      wb_q.push_back('0);
      wb_q.push_back('0);
      wb_q.push_back('0);

      @(negedge Clk);
      Reset = 1'b0;

      for (int e = 1; e <= NCYC; e++) begin
         if (e == S_ON) force dut.S = 1'b1;
         if (e == S_OFF + 1) begin
            force dut.S = 1'b0;
            release dut.S;
         end

         w  = word_at(32'(4 * (e - 1)));
         cs = dec(w);
         if (s_at(e + 1)) begin
            ex_q.push_back('0);
            mem_q.push_back('0);
            wb_q.push_back('0);
         end else begin
            ex_q.push_back(cs);
            mem_q.push_back(narrow(cs));
            wb_q.push_back({cs[6], cs[5]});
         end

         @(posedge Clk);
         #1;
         check("pc", dut.PC, 32'(4 * e));
         check("ir", dut.IF_ID_instruction, w);
         check("cs", 32'(dut.control_unit.control_signals), 32'(cs));
         check("s", 32'(dut.S), 32'(s_at(e)));
         if (e <= 6)
            check("cs_ref", 32'(dut.control_unit.control_signals),
                  32'(cs_tbl[e-1]));
         if (e >= 3 && e <= 8)
            check("mem_ref", 32'(dut.MEM_control_signals),
                  32'(mem_tbl[e-3]));
         if (e >= 4 && e <= 9)
            check("wb_ref", 32'(dut.WB_control_signals),
                  32'(wb_tbl[e-4]));

         if (ex_q.size() == 0) check("ex_q_empty", 32'd1, 32'd0);
         else begin
            exp_ex = 32'(ex_q.pop_front());
            check("ex", 32'(dut.EX_control_signals), exp_ex);
         end
         if (mem_q.size() == 0) check("mem_q_empty", 32'd1, 32'd0);
         else check("mem", 32'(dut.MEM_control_signals),
                    32'(mem_q.pop_front()));
         if (wb_q.size() == 0) check("wb_q_empty", 32'd1, 32'd0);
         else check("wb", 32'(dut.WB_control_signals),
                    32'(wb_q.pop_front()));
      end

      // Asynchronous reset between edges.
      #2;
      Reset = 1'b1;
      #1;
      check("arst_pc", dut.PC, 32'd0);
      check("arst_ir", dut.IF_ID_instruction, 32'd0);
      check("arst_ex", 32'(dut.EX_control_signals), 32'd0);
      check("arst_mem", 32'(dut.MEM_control_signals), 32'd0);
      check("arst_wb", 32'(dut.WB_control_signals), 32'd0);
      check("arst_s", 32'(dut.S), 32'd0);

      @(negedge Clk);
      Reset = 1'b0;
      @(posedge Clk);
      #1;
      check("restart_pc", dut.PC, 32'd4);
      check("restart_ir", dut.IF_ID_instruction, prog[0]);
      check("restart_cs", 32'(dut.control_unit.control_signals),
            32'(cs_tbl[0]));
      check("restart_ex", 32'(dut.EX_control_signals), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
